// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals shared by mem_port_arbiter.
// master: the arbiter's view; slave: the CPU channels and the memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] inst_req_addr;
    logic              inst_req_valid;
    logic              inst_req_ready;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_rvalid;
    logic              inst_rready;

    logic [ADDR_W-1:0] data_addr;
    logic              data_read;
    logic              data_write;
    logic [DATA_W-1:0] data_wdata;
    logic [STRB_W-1:0] data_wstrb;
    logic              data_req_ready;
    logic [DATA_W-1:0] data_rdata;
    logic              data_rvalid;
    logic              data_rready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_read;
    logic              mem_write;
    logic              mem_req_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_rready;

    modport master (
        input  inst_req_addr, inst_req_valid, inst_rready,
        input  data_addr, data_read, data_write, data_wdata, data_wstrb, data_rready,
        input  mem_req_ready, mem_rdata, mem_rvalid,
        output inst_req_ready, inst_rdata, inst_rvalid,
        output data_req_ready, data_rdata, data_rvalid,
        output mem_addr, mem_wdata, mem_wstrb, mem_read, mem_write, mem_rready
    );

    modport slave (
        output inst_req_addr, inst_req_valid, inst_rready,
        output data_addr, data_read, data_write, data_wdata, data_wstrb, data_rready,
        output mem_req_ready, mem_rdata, mem_rvalid,
        input  inst_req_ready, inst_rdata, inst_rvalid,
        input  data_req_ready, data_rdata, data_rvalid,
        input  mem_addr, mem_wdata, mem_wstrb, mem_read, mem_write, mem_rready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Optional ARB_PERF_CNT_EN adds grant and conflict counters.
module mem_port_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.master    bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_inst_grant,
    output logic [31:0]           perf_data_grant,
    output logic [31:0]           perf_conflict
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
    typedef enum logic {SIDE_INST, SIDE_DATA} side_e;

    state_e state_q;
    side_e  owner_q;
    side_e  last_grant_q;
    side_e  grant_d;
    logic   inst_pend;
    logic   data_pend;
    logic   any_pend;
    logic   req_live;

    // Round-robin choice: on a conflict the side not served last time wins.
    always_comb begin
        inst_pend = bus.inst_req_valid;
        data_pend = bus.data_read | bus.data_write;
        any_pend  = inst_pend | data_pend;
        grant_d   = SIDE_DATA;
        if (inst_pend && data_pend) begin
            grant_d = (last_grant_q == SIDE_DATA) ? SIDE_INST : SIDE_DATA;
        end else if (inst_pend) begin
            grant_d = SIDE_INST;
        end
    end

    assign req_live = bus.mem_read | bus.mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= SIDE_INST;
            last_grant_q <= SIDE_DATA;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_pend) begin
                        state_q      <= ST_REQ;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                    end
                end
                ST_REQ: begin
                    // A request withdrawn before acceptance ends the turn with no access.
                    if (req_live && bus.mem_req_ready) begin
                        state_q <= bus.mem_read ? ST_RESP : ST_IDLE;
                    end else if (!req_live) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (bus.mem_rvalid && bus.mem_rready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Steer the owner's request to memory and the memory response back to the owner.
    always_comb begin
        bus.inst_req_ready = 1'b0;
        bus.inst_rdata     = '0;
        bus.inst_rvalid    = 1'b0;
        bus.data_req_ready = 1'b0;
        bus.data_rdata     = '0;
        bus.data_rvalid    = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.mem_wstrb      = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_rready     = 1'b0;
        if (state_q == ST_REQ) begin
            if (owner_q == SIDE_INST) begin
                bus.mem_addr       = bus.inst_req_addr;
                bus.mem_read       = bus.inst_req_valid;
                bus.inst_req_ready = bus.mem_req_ready;
            end else begin
                bus.mem_addr       = bus.data_addr;
                bus.mem_wdata      = bus.data_wdata;
                bus.mem_wstrb      = bus.data_wstrb;
                bus.mem_write      = bus.data_write;
                bus.mem_read       = bus.data_read & ~bus.data_write;
                bus.data_req_ready = bus.mem_req_ready;
            end
        end else if (state_q == ST_RESP) begin
            if (owner_q == SIDE_INST) begin
                bus.mem_rready  = bus.inst_rready;
                bus.inst_rvalid = bus.mem_rvalid;
                bus.inst_rdata  = bus.mem_rdata;
            end else begin
                bus.mem_rready  = bus.data_rready;
                bus.data_rvalid = bus.mem_rvalid;
                bus.data_rdata  = bus.mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] inst_grant_q;
    logic [CNT_W-1:0] data_grant_q;
    logic [CNT_W-1:0] conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_grant_q <= '0;
            data_grant_q <= '0;
            conflict_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            if (any_pend && grant_d == SIDE_INST) inst_grant_q <= inst_grant_q + CNT_W'(1);
            if (any_pend && grant_d == SIDE_DATA) data_grant_q <= data_grant_q + CNT_W'(1);
            if (inst_pend && data_pend)           conflict_q   <= conflict_q + CNT_W'(1);
        end
    end

    assign perf_inst_grant = inst_grant_q;
    assign perf_data_grant = data_grant_q;
    assign perf_conflict   = conflict_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random CPU/memory traffic against a queue scoreboard.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mtx_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_inst_grant, perf_data_grant, perf_conflict;
    mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus),
        .perf_inst_grant(perf_inst_grant), .perf_data_grant(perf_data_grant),
        .perf_conflict(perf_conflict));
`else
    mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    mtx_t        inst_mq[$];
    mtx_t        data_mq[$];
    logic [31:0] inst_rq[$];
    logic [31:0] data_rq[$];
    bit          rnd_done;

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects requests already raised with the arbiter in IDLE; serves one read for the expected winner.
    task automatic grant_check(input bit exp_inst, input string nm, input logic [31:0] rdat);
        bus.mem_req_ready = 1'b1;
        tick();
        chk({nm, "_inst_ready"}, 64'(bus.inst_req_ready), 64'(exp_inst));
        chk({nm, "_data_ready"}, 64'(bus.data_req_ready), 64'(!exp_inst));
        tick();
        if (exp_inst) bus.inst_req_valid = 1'b0;
        else          bus.data_read = 1'b0;
        bus.inst_rready = 1'b1;
        bus.data_rready = 1'b1;
        bus.mem_rvalid  = 1'b1;
        bus.mem_rdata   = rdat;
        #1;
        chk({nm, "_rdata"}, 64'(exp_inst ? bus.inst_rdata : bus.data_rdata), 64'(rdat));
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.inst_req_addr = '0; bus.inst_req_valid = 1'b0; bus.inst_rready = 1'b0;
        bus.data_addr = '0; bus.data_read = 1'b0; bus.data_write = 1'b0;
        bus.data_wdata = '0; bus.data_wstrb = '0; bus.data_rready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        rnd_done = 1'b0;
        repeat (2) tick();
        chk("rst_mem_read", 64'(bus.mem_read), 64'd0);
        chk("rst_readies", 64'({bus.inst_req_ready, bus.data_req_ready, bus.mem_rready}), 64'd0);
        rst = 1'b0;

        // Single fetch after reset: accepted one cycle after it is seen.
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'h0;
        bus.mem_req_ready = 1'b1; bus.mem_rdata = 32'h0000_0013;
        #1;
        chk("t1_ready_cycle0", 64'(bus.inst_req_ready), 64'd0);
        tick();
        chk("t1_ready_cycle1", 64'(bus.inst_req_ready), 64'd1);
        chk("t1_mem_read", 64'({bus.mem_read, bus.mem_write}), 64'b10);
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'h0);
        chk("t1_data_quiet", 64'(bus.data_req_ready), 64'd0);
        tick();
        bus.inst_req_valid = 1'b0; bus.inst_rready = 1'b1; bus.mem_rvalid = 1'b1;
        #1;
        chk("t1_rvalid", 64'(bus.inst_rvalid), 64'd1);
        chk("t1_rdata", 64'(bus.inst_rdata), 64'h13);
        chk("t1_data_rvalid", 64'(bus.data_rvalid), 64'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("t1_rvalid_end", 64'(bus.inst_rvalid), 64'd0);

        // Conflicts after a fresh reset: fetch first, then alternate.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'h40;
        bus.data_read = 1'b1; bus.data_addr = 32'h8000_0300;
        grant_check(1'b1, "t2_first", 32'h1111_0001);
        grant_check(1'b0, "t2_second", 32'h2222_0002);
        bus.inst_req_valid = 1'b1; bus.data_read = 1'b1;
        grant_check(1'b1, "t2_third", 32'h3333_0003);
        bus.inst_req_valid = 1'b1;
        grant_check(1'b0, "t2_swap", 32'h4444_0004);
        bus.inst_req_valid = 1'b0;

        // Store stalled by memory for three cycles.
        bus.data_write = 1'b1; bus.data_addr = 32'h100;
        bus.data_wdata = 32'hAABB_CCDD; bus.data_wstrb = 4'b0100; bus.mem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_req_ready = 1'b1;
            #1;
            chk("t3_mem_write", 64'({bus.mem_write, bus.mem_read}), 64'b10);
            chk("t3_payload", {bus.mem_addr[27:0], bus.mem_wstrb, bus.mem_wdata}, {28'h100, 4'b0100, 32'hAABB_CCDD});
            chk("t3_ready", 64'(bus.data_req_ready), 64'(i == 3));
            tick();
        end
        bus.data_write = 1'b0;
        #1;
        chk("t3_after", 64'({bus.mem_write, bus.data_rvalid}), 64'd0);

        // Load whose response waits on data_rready.
        bus.data_read = 1'b1; bus.data_addr = 32'h200;
        tick(); tick();
        bus.data_read = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678; bus.data_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.data_rready = 1'b1;
            #1;
            chk("t4_rvalid", 64'(bus.data_rvalid), 64'd1);
            chk("t4_rdata", 64'(bus.data_rdata), 64'h1234_5678);
            chk("t4_rready", 64'(bus.mem_rready), 64'(i == 2));
            tick();
        end
        bus.mem_rvalid = 1'b0;
        #1;
        chk("t4_done", 64'(bus.data_rvalid), 64'd0);

        // Reset asserted in the middle of a response.
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'h44;
        tick(); tick();
        bus.inst_req_valid = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t5_pre_rvalid", 64'(bus.inst_rvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_out", 64'({bus.inst_rvalid, bus.mem_rready, bus.inst_req_ready, bus.mem_read}), 64'd0);
        chk("t5_rst_data", 64'(bus.inst_rdata), 64'd0);
        tick();
        rst = 1'b0; bus.mem_rvalid = 1'b0;
        bus.inst_req_valid = 1'b1; bus.inst_req_addr = 32'h48;
        grant_check(1'b1, "t5_refetch", 32'h5555_0005);

`ifdef ARB_PERF_CNT_EN
        rst = 1'b1; tick(); rst = 1'b0;
        chk("perf_rst_inst", 64'(perf_inst_grant), 64'd0);
        for (int k = 0; k < 2; k++) begin
            bus.inst_req_valid = 1'b1; bus.data_read = 1'b1;
            grant_check(1'b1, "perf_c_inst", 32'h7);
            grant_check(1'b0, "perf_c_data", 32'h8);
        end
        for (int k = 0; k < 4; k++) begin
            if (k < 3) bus.inst_req_valid = 1'b1;
            else       bus.data_read = 1'b1;
            grant_check(k < 3, "perf_single", 32'h9);
        end
        chk("perf_cnts", {perf_inst_grant[15:0], perf_data_grant[15:0], perf_conflict}, {16'd5, 16'd3, 32'd2});
        rst = 1'b1; #1;
        chk("perf_clear", {perf_inst_grant[15:0], perf_data_grant[15:0], perf_conflict}, 64'd0);
        tick(); rst = 1'b0;
`endif

        // Random traffic checked by the scoreboard.
        fork
            begin : inst_agent
                bit          ia_ok;
                logic [31:0] ia_addr;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    ia_addr = {1'b0, 29'($urandom), 2'b00};
                    bus.inst_req_addr = ia_addr; bus.inst_req_valid = 1'b1;
                    inst_mq.push_back('{rd: 1'b1, wr: 1'b0, addr: ia_addr, wdata: '0, wstrb: '0});
                    inst_rq.push_back(hsh(ia_addr));
                    ia_ok = 1'b0;
                    for (int w = 0; w < 300 && !ia_ok; w++) begin
                        @(negedge clk);
                        ia_ok = bus.inst_req_ready;
                    end
                    if (!ia_ok) begin total++; bad++; $display("FAIL inst_accept: timeout at fetch %0d", n); end
                    tick();
                    bus.inst_req_valid = 1'b0;
                end
            end
            begin : data_agent
                bit          da_ok;
                mtx_t        da_t;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    da_t.addr  = {1'b1, 29'($urandom), 2'b00};
                    da_t.wdata = $urandom;
                    da_t.wstrb = 4'($urandom);
                    da_t.wr    = ($urandom_range(0, 2) == 0);
                    da_t.rd    = !da_t.wr;
                    bus.data_addr = da_t.addr; bus.data_wdata = da_t.wdata; bus.data_wstrb = da_t.wstrb;
                    bus.data_write = da_t.wr;
                    bus.data_read  = da_t.rd | (da_t.wr && $urandom_range(0, 1) == 1);
                    data_mq.push_back(da_t);
                    if (da_t.rd) data_rq.push_back(hsh(da_t.addr));
                    da_ok = 1'b0;
                    for (int w = 0; w < 300 && !da_ok; w++) begin
                        @(negedge clk);
                        da_ok = bus.data_req_ready;
                    end
                    if (!da_ok) begin total++; bad++; $display("FAIL data_accept: timeout at op %0d", n); end
                    tick();
                    bus.data_read = 1'b0; bus.data_write = 1'b0;
                end
            end
            begin : memory
                bit          m_fire, m_done, m_pend;
                int          m_delay;
                logic [31:0] m_data;
                m_pend = 1'b0; m_delay = 0; m_data = '0;
                for (int c = 0; c < 5000; c++) begin
                    @(negedge clk);
                    m_fire = bus.mem_read && bus.mem_req_ready;
                    m_done = bus.mem_rvalid && bus.mem_rready;
                    if (m_fire) m_data = hsh(bus.mem_addr);
                    tick();
                    if (m_done) begin bus.mem_rvalid = 1'b0; m_pend = 1'b0; end
                    if (m_fire) begin m_pend = 1'b1; m_delay = $urandom_range(0, 2); end
                    if (m_pend && !bus.mem_rvalid) begin
                        if (m_delay == 0) bus.mem_rvalid = 1'b1;
                        else m_delay--;
                    end
                    bus.mem_rdata     = bus.mem_rvalid ? m_data : $urandom;
                    bus.mem_req_ready = ($urandom_range(0, 3) != 0);
                    bus.inst_rready   = ($urandom_range(0, 2) != 0);
                    bus.data_rready   = ($urandom_range(0, 2) != 0);
                end
                rnd_done = 1'b1;
            end
            begin : monitor
                mtx_t        mo_e;
                logic [31:0] mo_r;
                while (!rnd_done) begin
                    @(negedge clk);
                    if ((bus.mem_read || bus.mem_write) && bus.mem_req_ready) begin
                        if (!bus.mem_addr[31]) begin
                            if (inst_mq.size() == 0) begin total++; bad++; $display("FAIL sb_inst_req: unexpected addr %0h", bus.mem_addr); end
                            else begin
                                mo_e = inst_mq.pop_front();
                                chk("sb_inst_req", {bus.mem_read, bus.mem_write, bus.mem_wstrb, bus.mem_addr}, {mo_e.rd, mo_e.wr, 4'h0, mo_e.addr});
                            end
                        end else begin
                            if (data_mq.size() == 0) begin total++; bad++; $display("FAIL sb_data_req: unexpected addr %0h", bus.mem_addr); end
                            else begin
                                mo_e = data_mq.pop_front();
                                chk("sb_data_req", {bus.mem_read, bus.mem_write, bus.mem_addr}, {mo_e.rd, mo_e.wr, mo_e.addr});
                                if (mo_e.wr) chk("sb_data_wr", {bus.mem_wstrb, bus.mem_wdata}, {mo_e.wstrb, mo_e.wdata});
                            end
                        end
                    end
                    if (bus.inst_rvalid || bus.data_rvalid)
                        chk("sb_rvalid_excl", 64'(bus.inst_rvalid & bus.data_rvalid), 64'd0);
                    if (bus.inst_rvalid && bus.inst_rready) begin
                        if (inst_rq.size() == 0) begin total++; bad++; $display("FAIL sb_inst_rsp: unexpected %0h", bus.inst_rdata); end
                        else begin mo_r = inst_rq.pop_front(); chk("sb_inst_rsp", 64'(bus.inst_rdata), 64'(mo_r)); end
                    end
                    if (bus.data_rvalid && bus.data_rready) begin
                        if (data_rq.size() == 0) begin total++; bad++; $display("FAIL sb_data_rsp: unexpected %0h", bus.data_rdata); end
                        else begin mo_r = data_rq.pop_front(); chk("sb_data_rsp", 64'(bus.data_rdata), 64'(mo_r)); end
                    end
                end
            end
        join

        chk("sb_inst_left", 64'(inst_mq.size() + inst_rq.size()), 64'd0);
        chk("sb_data_left", 64'(data_mq.size() + data_rq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
